// File: rtl/music_pkg.sv
// Shared types and defaults for the music beat scheduler.
package music_pkg;

    // Player states seen by the game FSM through the playing flag
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_BEAT_W     = 12;
    localparam int DEF_TEMPO_DIV  = 3125000;
    localparam int DEF_SONG_LEN_0 = 256;
    localparam int DEF_SONG_LEN_1 = 128;
    localparam int DEF_SONG_LEN_2 = 64;
    localparam int DEF_SONG_LEN_3 = 512;

    // Song length lookup; lengths are passed in so each instance can retune them
    function automatic int song_len(input logic [1:0] sel,
                                    input int l0, input int l1,
                                    input int l2, input int l3);
        case (sel)
            2'd0:    song_len = l0;
            2'd1:    song_len = l1;
            2'd2:    song_len = l2;
            2'd3:    song_len = l3;
            default: song_len = l0;
        endcase
    endfunction

endpackage

// File: rtl/music_scheduler_tempo_divider.sv
// Beat-period divider: counts clock cycles within one beat and raises tick
// on the last cycle. The beat length is chosen from fast only when a new
// beat starts, so a beat already in progress is never shortened.
module tempo_divider
    import music_pkg::*;
#(
    parameter int TEMPO_DIV = DEF_TEMPO_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic abort,
    input  logic run,
    input  logic fast,
    output logic tick
);

    localparam int CNT_W = $clog2(TEMPO_DIV + 1);
    localparam logic [CNT_W-1:0] FULL_PERIOD = CNT_W'(TEMPO_DIV);
    localparam logic [CNT_W-1:0] HALF_PERIOD = CNT_W'(TEMPO_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    logic [CNT_W-1:0] div_cnt_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] period_sel_s;
    logic             tc_s;

    // Length of the next beat as selected by the tempo level
    always_comb begin
        period_sel_s = FULL_PERIOD;
        if (fast) begin
            period_sel_s = HALF_PERIOD;
        end else begin
            period_sel_s = FULL_PERIOD;
        end
    end

    // Terminal count of the current beat
    always_comb begin
        tc_s = (div_cnt_r == (period_r - CNT_ONE));
    end

    assign tick = run & tc_s;

    // Cycle counter and beat length; abort outranks restart, frozen when not running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= CNT_ZERO;
            period_r  <= FULL_PERIOD;
        end else if (abort) begin
            div_cnt_r <= CNT_ZERO;
        end else if (restart) begin
            div_cnt_r <= CNT_ZERO;
            period_r  <= period_sel_s;
        end else if (run && tc_s) begin
            div_cnt_r <= CNT_ZERO;
            period_r  <= period_sel_s;
        end else if (run) begin
            div_cnt_r <= div_cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/music_scheduler.sv
// Commanded beat sequencer for the red-light/green-light music ROM.
// Takes start/stop/pause/loop/fast from the game FSM, steps the beat index
// at each tempo tick and reports playing status and song completion.
module music_scheduler
    import music_pkg::*;
#(
    parameter int TEMPO_DIV  = DEF_TEMPO_DIV,
    parameter int BEAT_W     = DEF_BEAT_W,
    parameter int SONG_LEN_0 = DEF_SONG_LEN_0,
    parameter int SONG_LEN_1 = DEF_SONG_LEN_1,
    parameter int SONG_LEN_2 = DEF_SONG_LEN_2,
    parameter int SONG_LEN_3 = DEF_SONG_LEN_3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        song_id,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic              fast,
    output logic [BEAT_W-1:0] ibeat,
    output logic [1:0]        song_sel,
    output logic              playing,
    output logic              beat_tick,
    output logic              song_done
);

    // One extra bit so a length of exactly 2^BEAT_W still compares correctly
    localparam int LEN_W = BEAT_W + 1;
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);

    state_t            state_r;
    state_t            state_n_s;
    logic [BEAT_W-1:0] ibeat_r;
    logic [BEAT_W-1:0] ibeat_n_s;
    logic [1:0]        song_sel_r;
    logic [1:0]        song_sel_n_s;
    logic [LEN_W-1:0]  len_s;
    logic [LEN_W-1:0]  beat_inc_s;
    logic              last_s;
    logic              run_s;
    logic              restart_s;
    logic              tick_s;

    // Divider only counts in PLAY on cycles with no overriding command
    always_comb begin
        restart_s = start & ~stop;
        run_s     = (state_r == PLAY) & ~stop & ~start & ~pause;
    end

    tempo_divider #(
        .TEMPO_DIV (TEMPO_DIV)
    ) u_tempo_divider (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_s),
        .abort   (stop),
        .run     (run_s),
        .fast    (fast),
        .tick    (tick_s)
    );

    // Last-beat detection against the length of the latched song
    always_comb begin
        len_s      = LEN_W'(song_len(song_sel_r, SONG_LEN_0, SONG_LEN_1,
                                     SONG_LEN_2, SONG_LEN_3));
        beat_inc_s = {1'b0, ibeat_r} + LEN_ONE;
        last_s     = ~(beat_inc_s < len_s);
    end

    // Next state, beat index and song select; stop > start > pause
    always_comb begin
        state_n_s    = state_r;
        ibeat_n_s    = ibeat_r;
        song_sel_n_s = song_sel_r;
        if (stop) begin
            state_n_s = IDLE;
            ibeat_n_s = BEAT_ZERO;
        end else if (start) begin
            state_n_s    = PLAY;
            ibeat_n_s    = BEAT_ZERO;
            song_sel_n_s = song_id;
        end else begin
            case (state_r)
                PLAY: begin
                    if (pause) begin
                        state_n_s = PAUSE;
                    end else if (tick_s) begin
                        if (!last_s) begin
                            ibeat_n_s = beat_inc_s[BEAT_W-1:0];
                        end else if (loop) begin
                            ibeat_n_s = BEAT_ZERO;
                        end else begin
                            state_n_s = DONE;
                        end
                    end else begin
                        state_n_s = PLAY;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_n_s = PLAY;
                    end else begin
                        state_n_s = PAUSE;
                    end
                end
                IDLE:    state_n_s = IDLE;
                DONE:    state_n_s = DONE;
                default: begin
                    state_n_s = IDLE;
                    ibeat_n_s = BEAT_ZERO;
                end
            endcase
        end
    end

    // State, beat index and song select registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            ibeat_r    <= BEAT_ZERO;
            song_sel_r <= 2'd0;
        end else begin
            state_r    <= state_n_s;
            ibeat_r    <= ibeat_n_s;
            song_sel_r <= song_sel_n_s;
        end
    end

    assign ibeat     = ibeat_r;
    assign song_sel  = song_sel_r;
    assign playing   = (state_r == PLAY);
    assign beat_tick = tick_s;
    assign song_done = tick_s & last_s;

endmodule

// File: tb/tb_music_scheduler.sv
// Bench for music_scheduler: directed scenarios plus random commands, every
// cycle compared against a cycle-scheduled behavioural model.
module tb_music_scheduler;

    localparam int TD = 4;
    localparam int BW = 3;
    localparam int L0 = 3;
    localparam int L1 = 5;
    localparam int L2 = 2;
    localparam int L3 = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    song_id;
    logic          stop;
    logic          pause;
    logic          loop;
    logic          fast;
    logic [BW-1:0] ibeat;
    logic [1:0]    song_sel;
    logic          playing;
    logic          beat_tick;
    logic          song_done;

    music_scheduler #(
        .TEMPO_DIV  (TD),
        .BEAT_W     (BW),
        .SONG_LEN_0 (L0),
        .SONG_LEN_1 (L1),
        .SONG_LEN_2 (L2),
        .SONG_LEN_3 (L3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .song_id   (song_id),
        .stop      (stop),
        .pause     (pause),
        .loop      (loop),
        .fast      (fast),
        .ibeat     (ibeat),
        .song_sel  (song_sel),
        .playing   (playing),
        .beat_tick (beat_tick),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 play, 2 pause, 3 done. The next tick is kept as
    // an absolute cycle number that slides by one for every frozen cycle.
    int lens [4] = '{L0, L1, L2, L3};
    int m_mode, m_beat, m_sel, m_next_tick;
    int cyc;
    int n_vec, n_err;
    int tick_log[$];
    int done_log[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (q.size() > i) return q[i];
        return -1;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_beat = 0; m_sel = 0; m_next_tick = 0;
    endfunction

    function automatic bit model_tick();
        return (m_mode == 1) && !stop && !start && !pause && (cyc == m_next_tick);
    endfunction

    task automatic compare_outputs();
        bit tk;
        tk = model_tick();
        check("ibeat",     int'(ibeat),     m_beat);
        check("song_sel",  int'(song_sel),  m_sel);
        check("playing",   int'(playing),   int'(m_mode == 1));
        check("beat_tick", int'(beat_tick), int'(tk));
        check("song_done", int'(song_done), int'(tk && (m_beat == lens[m_sel] - 1)));
    endtask

    function automatic void model_update();
        bit tk;
        int blen;
        tk   = model_tick();
        blen = fast ? TD / 2 : TD;
        if (tk) tick_log.push_back(cyc);
        if (tk && m_beat == lens[m_sel] - 1) done_log.push_back(cyc);
        if (reset) begin
            model_reset();
        end else if (stop) begin
            m_mode = 0; m_beat = 0;
        end else if (start) begin
            m_sel = int'(song_id); m_beat = 0; m_mode = 1;
            m_next_tick = cyc + blen;
        end else if (m_mode == 1) begin
            if (pause) begin
                m_mode = 2; m_next_tick++;
            end else if (tk) begin
                if (m_beat + 1 < lens[m_sel]) m_beat++;
                else if (loop) m_beat = 0;
                else m_mode = 3;
                m_next_tick = cyc + blen;
            end
        end else if (m_mode == 2) begin
            m_next_tick++;
            if (!pause) m_mode = 1;
        end
    endfunction

    // One cycle: drive after the edge, compare settled outputs, advance model
    task automatic step(input logic st, input logic sp, input logic ps,
                        input logic lp, input logic fs, input logic [1:0] sid);
        start = st; stop = sp; pause = ps; loop = lp; fast = fs; song_id = sid;
        #3;
        compare_outputs();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int s, s2, cap_a, cap_b;
    logic pz, lp_l, fs_l;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0; fast = 1'b0; song_id = 2'd0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: song 0 (3 beats), start at cycle 10, no loop
        tick_log.delete(); done_log.delete();
        for (int i = 0; i < 30; i++) step(i == 10, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("s1_tick0", qget(tick_log, 0), 14);
        check("s1_tick1", qget(tick_log, 1), 18);
        check("s1_tick2", qget(tick_log, 2), 22);
        check("s1_ntick", tick_log.size(), 3);
        check("s1_done",  qget(done_log, 0), 22);
        check("s1_beat",  m_beat, 2);
        check("s1_mode",  m_mode, 3);

        // 2: same song with loop
        s = cyc; cap_a = -1;
        tick_log.delete(); done_log.delete();
        for (int i = 0; i < 20; i++) begin
            if (cyc == s + 13) cap_a = m_beat;
            step(i == 0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        end
        check("s2_done", qget(done_log, 0), s + 12);
        check("s2_wrap", cap_a, 0);
        check("s2_tick", qget(tick_log, 3), s + 16);
        check("s2_mode", m_mode, 1);

        // 3: song 1, pause during relative cycles 5..10
        s = cyc; cap_a = -1;
        tick_log.delete(); done_log.delete();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) cap_a = m_beat;
            step(i == 0, 1'b0, (i >= 5 && i <= 10), 1'b0, 1'b0, 2'd1);
        end
        check("s3_tick0", qget(tick_log, 0), s + 4);
        check("s3_tick1", qget(tick_log, 1), s + 15);
        check("s3_beat",  cap_a, 1);

        // 4: fast raised mid-beat, then restart already fast
        s = cyc;
        tick_log.delete();
        for (int i = 0; i < 12; i++) step(i == 0, 1'b0, 1'b0, 1'b0, (i >= 2), 2'd1);
        check("s4_tick0", qget(tick_log, 0), s + 4);
        check("s4_tick1", qget(tick_log, 1), s + 6);
        check("s4_tick2", qget(tick_log, 2), s + 8);
        s2 = cyc;
        tick_log.delete();
        for (int i = 0; i < 6; i++) step(i == 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        check("s4_fast0", qget(tick_log, 0), s2 + 2);

        // 5: start+stop together, then restart song 2 at beat 1
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        check("s5_idle", m_mode, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("s5_beat1", m_beat, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        check("s5_sel", m_sel, 2);
        check("s5_beat0", m_beat, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // 6: asynchronous reset mid-PLAY on song 3
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0; fast = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk);
        #1; cyc++;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Random command traffic
        pz = 1'b0; lp_l = 1'b0; fs_l = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(11, 0) == 0) pz = ~pz;
            if ($urandom_range(39, 0) == 0) lp_l = ~lp_l;
            if ($urandom_range(19, 0) == 0) fs_l = ~fs_l;
            step(($urandom_range(24, 0) == 0), ($urandom_range(79, 0) == 0),
                 pz, lp_l, fs_l, 2'($urandom_range(3, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/music_scheduler.md
Name: music_scheduler

Overview:
Sequences the beat counter that drives the music ROM for the red-light/green-light game.
- Accepts play commands from the game FSM: start with a song select, pause, stop, loop and fast tempo.
- Generates the tempo beat tick and advances the beat index per song length.
- Reports play status and song completion back to the game FSM.
- Sits between the game FSM and the note ROM / tone generator; it replaces a free-running beat counter with a commanded one.

Parameters:
TEMPO_DIV, 3125000, clk cycles per beat at normal tempo (≥4, even)
BEAT_W, 12, beat index width
SONG_LEN_0, 256, beats in song 0
SONG_LEN_1, 128, beats in song 1
SONG_LEN_2, 64, beats in song 2
SONG_LEN_3, 512, beats in song 3 (all lengths 2..2^BEAT_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; begin/restart song_id from beat 0
song_id  in  2  song to play, sampled on start
stop  in  1  level/pulse; abort to IDLE
pause  in  1  level; freeze beat and divider while high
loop  in  1  level; on last beat wrap to 0 instead of finishing
fast  in  1  level; use TEMPO_DIV/2 for the next beat period
ibeat  out  BEAT_W  current beat index to note ROM
song_sel  out  2  latched song id to note ROM
playing  out  1  high in PLAY only
beat_tick  out  1  1-cycle pulse at each beat boundary
song_done  out  1  1-cycle pulse when last beat expires

Behaviour:
- Reset (async): state=IDLE, ibeat=0, song_sel=0, div_cnt=0, period=TEMPO_DIV, all pulses 0.
- States: IDLE, PLAY, PAUSE, DONE. Command priority per cycle: stop > start > pause.
- stop in any state: next state IDLE, ibeat=0, div_cnt=0, no beat_tick/song_done that cycle.
- start in any state (no stop): song_sel<=song_id, ibeat<=0, div_cnt<=0, period<=fast?TEMPO_DIV/2:TEMPO_DIV, state PLAY. A start while PLAY/PAUSE restarts.
- PLAY: div_cnt increments each cycle. When div_cnt==period-1: beat_tick=1 (combinational from registered state, same cycle), div_cnt<=0, period reloaded from fast.
  - If ibeat+1 < LEN[song_sel]: ibeat<=ibeat+1.
  - Else song_done=1 that cycle. With loop=1: ibeat<=0, stay in PLAY. With loop=0: ibeat holds LEN-1, state DONE.
- pause=1 in PLAY: next state PAUSE. ibeat, div_cnt and period are frozen; no tick is issued in that cycle even at terminal count.
- PAUSE with pause=0: back to PLAY; counting resumes from the frozen div_cnt.
- DONE: ibeat holds LEN-1, playing=0. Only start or stop leave this state.
- fast takes effect only at the next period reload; it never shortens a beat in progress.
- Length compare uses BEAT_W+1 bits so SONG_LEN=2^BEAT_W is legal.
- The first beat_tick after start occurs period cycles after the start cycle; the beat lands on ibeat=1 on the following cycle.

Decomposition:
- Package music_pkg: state enum (IDLE/PLAY/PAUSE/DONE), BEAT_W, the song length lookup function/table, default TEMPO_DIV.
- One sub-module, tempo_divider: div_cnt, period reload with fast select, freeze input, tick output.
- The FSM and beat counter remain in music_scheduler.

Test Plan:
1. TEMPO_DIV=4, SONG_LEN_0=3, start song 0 at cycle 10, loop=0 -> beat_tick at cycles 14, 18, 22; ibeat 0→1→2; song_done at 22; state DONE; ibeat stays 2.
2. Same with loop=1 -> song_done at 22, ibeat returns to 0 at 23, ticks continue every 4 cycles.
3. pause high cycles 15-20 mid-beat -> no tick in that window; remaining beat cycles resume after pause drops; ibeat unchanged while paused.
4. fast=1 asserted mid-beat -> current beat keeps 4 cycles, following beats take 2 cycles; restart with fast=1 gives first tick after 2 cycles.
5. start and stop together, then start with song 2 while PLAY at ibeat 1 -> stop wins (IDLE, ibeat 0); the restart latches song_sel=2, ibeat=0, and div_cnt=0.
6. Assert reset mid-PLAY, asynchronously between clock edges -> outputs go to reset values immediately; no beat_tick/song_done pulse; after release, state IDLE until start.
